// File: rtl/sev_seg_scan_pkg.sv
// sev_seg_pkg: shared segment encoding, range-limit helpers and converter state for sev_seg_scan
package sev_seg_pkg;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CONV = 1'b1} conv_state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return SEG_TAB[d];
  endfunction
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  function automatic logic [63:0] pow16(input int n);
    return 64'd1 << (4 * n);
  endfunction
endpackage

// File: rtl/sev_seg_scan_if.sv
// sev_seg_scan_if: load request and display outputs of sev_seg_scan
// master drives strobe/num/hex and reads busy/ovf/LEDs/sel; slave is the driver side
interface sev_seg_scan_if #(parameter int W = 16, parameter int SELW = 3);
  logic            strobe;
  logic [W-1:0]    num;
  logic            hex;
  logic            busy;
  logic            ovf;
  logic [6:0]      LEDs;
  logic [SELW-1:0] sel;
  modport master (output strobe, num, hex, input busy, ovf, LEDs, sel);
  modport slave  (input strobe, num, hex, output busy, ovf, LEDs, sel);
endinterface

// File: rtl/sev_seg_scan_bin2bcd.sv
// bin2bcd: sequential double-dabble, one shift per cycle, W cycles per conversion
// ports: clk, reset (async active-low), i_start, i_bin, o_busy, o_done (last shift cycle),
//        o_bcd (digits after the shift happening this cycle), o_carry (bit shifted out of the top digit)
module bin2bcd
  import sev_seg_pkg::*;
#(
  parameter int W    = 16,
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [W-1:0]      i_bin,
  output logic              o_busy,
  output logic              o_done,
  output logic [4*NDIG-1:0] o_bcd,
  output logic              o_carry
);
  localparam int CW = $clog2(W);
  conv_state_t       r_state;
  logic [W-1:0]      r_bin;
  logic [4*NDIG-1:0] r_bcd;
  logic [4*NDIG-1:0] w_adj;
  logic [CW-1:0]     r_cnt;
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NDIG; i++)
      w_adj[4*i +: 4] = r_bcd[4*i +: 4] > 4'd4 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end
  // o_bcd is the post-shift value so the caller can commit on the final shift edge
  assign o_bcd   = {w_adj[4*NDIG-2:0], r_bin[W-1]};
  assign o_carry = w_adj[4*NDIG-1];
  assign o_busy  = r_state == ST_CONV;
  assign o_done  = o_busy && r_cnt == CW'(W - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else if (o_done) begin
      r_state <= ST_IDLE;
    end else if (o_busy) begin
      r_bin   <= r_bin << 1;
      r_bcd   <= o_bcd;
      r_cnt   <= r_cnt + CW'(1);
    end else if (i_start) begin
      r_state <= ST_CONV;
      r_bin   <= i_bin;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end
  end
endmodule

// File: rtl/sev_seg_scan.sv
// sev_seg_scan: multi-digit seven-segment scan driver with decimal/hex conversion
// ports: clk, reset (async active-low), bus (sev_seg_scan_if.slave: strobe/num/hex in, busy/ovf/LEDs/sel out)
// option: define SEV_SEG_LZB_EN to blank leading zero digits (slot 0 always shown)
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int W    = 16,
  parameter int DIV  = 4,
  parameter int SELW = 3
) (
  input  logic clk,
  input  logic reset,
  sev_seg_scan_if.slave bus
);
  localparam logic [63:0] DEC_MAX = pow10(NDIG) - 64'd1;
  localparam logic [63:0] HEX_LIM = pow16(NDIG);
  localparam int          PW      = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0]     r_pre;
  logic [SELW-1:0]   r_slot, w_slot_nxt;
  logic [3:0]        r_dig [NDIG];
  logic [3:0]        w_dig_nxt [NDIG];
  logic [3:0]        w_cur;
  logic [6:0]        r_leds, w_seg;
  logic              r_ovf, w_ovf_nxt, r_dec_ovf;
  logic              w_busy, w_done, w_accept, w_tc, w_lz, w_carry;
  logic [4*NDIG-1:0] w_bcd;
  logic [63:0]       w_num;
  assign w_num      = 64'(bus.num);
  assign w_accept   = bus.strobe & ~w_busy;
  assign w_tc       = r_pre == PW'(DIV - 1);
  assign w_slot_nxt = !w_tc ? r_slot : r_slot == SELW'(NDIG - 1) ? '0 : r_slot + SELW'(1);
  bin2bcd #(.W(W), .NDIG(NDIG)) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept & ~bus.hex),
    .i_bin   (bus.num),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_carry (w_carry)
  );
  // digits change only on a hex accept or on the final conversion shift
  always_comb begin
    w_ovf_nxt = r_ovf;
    w_dig_nxt = r_dig;
    if (w_accept && bus.hex) begin
      w_ovf_nxt = w_num >= HEX_LIM;
      for (int i = 0; i < NDIG; i++) w_dig_nxt[i] = w_ovf_nxt ? 4'hF : w_num[4*i +: 4];
    end else if (w_done) begin
      w_ovf_nxt = r_dec_ovf | w_carry;
      for (int i = 0; i < NDIG; i++) w_dig_nxt[i] = w_ovf_nxt ? 4'd9 : w_bcd[4*i +: 4];
    end
  end
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NDIG; i++) if (SELW'(i) == w_slot_nxt) w_cur = w_dig_nxt[i];
  end
`ifdef SEV_SEG_LZB_EN
  // blank when this slot and every slot above it hold zero; overflow digits are never zero
  always_comb begin
    w_lz = w_slot_nxt != '0;
    for (int j = 0; j < NDIG; j++) if (j >= int'(w_slot_nxt) && w_dig_nxt[j] != 4'd0) w_lz = 1'b0;
  end
`else
  assign w_lz = 1'b0;
`endif
  assign w_seg = w_lz ? SEG_BLANK : seg7(w_cur);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre     <= '0;
      r_slot    <= '0;
      r_dig     <= '{default: '0};
      r_ovf     <= 1'b0;
      r_dec_ovf <= 1'b0;
      r_leds    <= 7'b1000000;
    end else begin
      r_pre     <= w_tc ? '0 : r_pre + PW'(1);
      r_slot    <= w_slot_nxt;
      r_dig     <= w_dig_nxt;
      r_ovf     <= w_ovf_nxt;
      r_leds    <= w_seg;
      if (w_accept && !bus.hex) r_dec_ovf <= w_num > DEC_MAX;
    end
  end
  assign bus.busy = w_busy;
  assign bus.ovf  = r_ovf;
  assign bus.LEDs = r_leds;
  assign bus.sel  = r_slot;
endmodule
